// File: rtl/time_set_controller_pkg.sv
// Shared definitions for the time-set controller: mode encodings, the
// seconds/minutes moduli and the mode-advance sequence.
package time_set_controller_pkg;

  // Mode encodings as seen on the set_mode output.
  localparam logic [1:0] MODE_RUN      = 2'b00;
  localparam logic [1:0] MODE_SET_HOUR = 2'b01;
  localparam logic [1:0] MODE_SET_MIN  = 2'b10;

  localparam int unsigned SEC_MODULO = 60;
  localparam int unsigned MIN_MODULO = 60;

  // Mode reached after a mode_pulse. The unused encoding 11 falls back to RUN.
  function automatic logic [1:0] next_mode(input logic [1:0] mode);
    case (mode)
      MODE_RUN:      next_mode = MODE_SET_HOUR;
      MODE_SET_HOUR: next_mode = MODE_SET_MIN;
      default:       next_mode = MODE_RUN;
    endcase
  endfunction

endpackage

// File: rtl/time_set_controller_mod_counter.sv
// Generic wrap-around counter used for seconds, minutes and hours.
// carry_out is combinational so the next stage can increment on the same edge.
module mod_counter #(
  parameter int unsigned MODULO = 60,
  parameter int unsigned WIDTH  = 6
) (
  input  logic             regular_clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clear,
  output logic [WIDTH-1:0] value,
  output logic             carry_out
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULO - 1);

  // Carry fires only on the increment that wraps the counter.
  assign carry_out = inc && (value == LAST);

  // Count register: clear has priority over inc.
  // NOTE: state registers use non-blocking assignments so every counter
  // samples the pre-edge values of the others, giving a clean one-edge ripple.
  always_ff @(posedge regular_clk or posedge reset) begin
    if (reset) begin
      value <= '0;
    end else if (clear) begin
      value <= '0;
    end else if (inc) begin
      value <= carry_out ? '0 : value + WIDTH'(1);
    end
  end

endmodule

// File: rtl/time_set_controller.sv
// Clock time keeper with a three-mode button interface: RUN counts seconds,
// SET_HOUR and SET_MIN freeze the time and let inc_pulse adjust one field.
// HOURS_MODULO is 12 or 24.
module time_set_controller
  import time_set_controller_pkg::*;
#(
  parameter int unsigned HOURS_MODULO = 24
) (
  input  logic       regular_clk,
  input  logic       reset,
  input  logic       sec_tick,
  input  logic       mode_pulse,
  input  logic       inc_pulse,
  output logic [4:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic [1:0] set_mode,
  output logic       blink
);

  logic in_run;
  logic in_set_hour;
  logic in_set_min;
  logic adjust;
  logic sec_inc;
  logic min_inc;
  logic hour_inc;
  logic sec_clear;
  logic sec_carry;
  logic min_carry;
  logic hour_carry;
  logic [1:0] mode_after;

  assign in_run      = (set_mode == MODE_RUN);
  assign in_set_hour = (set_mode == MODE_SET_HOUR);
  assign in_set_min  = (set_mode == MODE_SET_MIN);
  assign mode_after  = next_mode(set_mode);

  // mode_pulse beats inc_pulse; sec_tick is still honoured alongside mode_pulse in RUN.
  assign adjust    = inc_pulse && !mode_pulse;
  assign sec_inc   = in_run && sec_tick;
  assign min_inc   = (in_run && sec_carry) || (in_set_min && adjust);
  assign hour_inc  = (in_run && min_carry) || (in_set_hour && adjust);
  assign sec_clear = in_set_min && mode_pulse;

  mod_counter #(.MODULO(SEC_MODULO), .WIDTH(6)) u_seconds (
    .regular_clk (regular_clk),
    .reset       (reset),
    .inc         (sec_inc),
    .clear       (sec_clear),
    .value       (seconds),
    .carry_out   (sec_carry)
  );

  mod_counter #(.MODULO(MIN_MODULO), .WIDTH(6)) u_minutes (
    .regular_clk (regular_clk),
    .reset       (reset),
    .inc         (min_inc),
    .clear       (1'b0),
    .value       (minutes),
    .carry_out   (min_carry)
  );

  mod_counter #(.MODULO(HOURS_MODULO), .WIDTH(5)) u_hours (
    .regular_clk (regular_clk),
    .reset       (reset),
    .inc         (hour_inc),
    .clear       (1'b0),
    .value       (hours),
    .carry_out   (hour_carry)
  );

  // Mode FSM and blink: blink is forced high on entering a set mode, low in
  // RUN, and toggles per sec_tick while setting. Encoding 11 recovers to RUN.
  always_ff @(posedge regular_clk or posedge reset) begin
    if (reset) begin
      set_mode <= MODE_RUN;
      blink    <= 1'b0;
    end else if (mode_pulse || !(in_run || in_set_hour || in_set_min)) begin
      set_mode <= mode_after;
      blink    <= (mode_after != MODE_RUN);
    end else if (in_run) begin
      blink <= 1'b0;
    end else if (sec_tick) begin
      blink <= ~blink;
    end
  end

  // The hour carry is not needed beyond the hours counter itself.
  logic unused_carry;
  assign unused_carry = hour_carry;

endmodule

// File: doc/time_set_controller.md
TIME_SET_CONTROLLER -- requirements
Module: time_set_controller

Interface
REQ-001 Parameter HOURS_MODULO, default 24: hour count wraps at this value; legal values are 12 and 24 only.
REQ-002 regular_clk  input  1  system clock, 31.5 MHz; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 sec_tick  input  1  one-cycle enable, one per second.
REQ-005 mode_pulse  input  1  one-cycle pulse from the mode-button debouncer.
REQ-006 inc_pulse  input  1  one-cycle pulse from the increment-button debouncer.
REQ-007 hours  output  5  current hours, 0..HOURS_MODULO-1.
REQ-008 minutes  output  6  current minutes, 0..59.
REQ-009 seconds  output  6  current seconds, 0..59.
REQ-010 set_mode  output  2  00 RUN, 01 SET_HOUR, 10 SET_MIN.
REQ-011 blink  output  1  digit-blink enable for the display stage.

Function
REQ-012 All outputs SHALL be registered and update in the cycle after the qualifying input cycle (latency 1).
REQ-013 The FSM SHALL advance on mode_pulse: RUN->SET_HOUR->SET_MIN->RUN; encoding 11 SHALL go to RUN on the next edge.
REQ-014 Each cycle an input is high SHALL count as one event; no internal edge detection.
REQ-015 In RUN, sec_tick SHALL increment seconds; 59->0 carries +1 to minutes.
REQ-016 In RUN, a minute wrap (59->0) SHALL carry +1 to hours, and hours SHALL wrap from HOURS_MODULO-1 to 0.
REQ-017 In RUN, the full rollover 23:59:59 (HOURS_MODULO=24) SHALL go to 00:00:00 in one cycle.
REQ-018 In RUN, inc_pulse SHALL be ignored.
REQ-019 In SET_HOUR, inc_pulse SHALL increment hours modulo HOURS_MODULO, with no effect on minutes or seconds.
REQ-020 In SET_MIN, inc_pulse SHALL increment minutes modulo 60 with no carry into hours.
REQ-021 In both set states, sec_tick SHALL NOT change the time; time is frozen.
REQ-022 The transition SET_MIN->RUN SHALL clear seconds to 0 on the same edge.
REQ-023 When mode_pulse and inc_pulse are high in the same cycle, mode_pulse SHALL win and inc_pulse SHALL be dropped.
REQ-024 When mode_pulse and sec_tick are high in the same cycle in RUN, both SHALL take effect: the tick applies to the time, then the state advances.
REQ-025 blink SHALL be 0 in RUN.
REQ-026 In set states, blink SHALL toggle on each sec_tick.
REQ-027 blink SHALL be forced to 1 on entry into SET_HOUR or SET_MIN.

Reset
REQ-028 Asserting reset SHALL immediately set hours=0, minutes=0, seconds=0, set_mode=RUN and blink=0, regardless of the clock.
REQ-029 Reset asserted mid-operation, including mid-set, SHALL discard all partial settings; there is no retained state.
REQ-030 After reset deasserts, the first sec_tick SHALL produce seconds=1.

Structure
REQ-031 A shared package SHALL hold the state encodings (RUN, SET_HOUR, SET_MIN), SEC_MODULO=60 and MIN_MODULO=60.
REQ-032 One sub-module, mod_counter, SHALL be instantiated three times (seconds, minutes, hours).
REQ-033 mod_counter SHALL be parameterised by modulo and width, with ports inc, clear, value and carry_out.
REQ-034 mod_counter carry_out SHALL be combinational and high only when inc is high and value equals modulo-1.

Verification
REQ-035 Reset, then 61 sec_ticks -> minutes=1, seconds=1, hours=0.
REQ-036 Preload 23:59:58 via set mode, return to RUN, 2 sec_ticks -> 00:00:00, set_mode=00.
REQ-037 mode_pulse, 25 inc_pulse -> hours=1 (wrap at 24), minutes unchanged; sec_ticks meanwhile -> time frozen, blink toggles each tick.
REQ-038 In SET_MIN, minutes=59, 1 inc_pulse -> minutes=0, hours unchanged; mode_pulse -> set_mode=00, seconds=0.
REQ-039 mode_pulse and inc_pulse in the same cycle from RUN -> set_mode=01, hours unchanged.
REQ-040 Reset pulse mid-SET_HOUR, asynchronous to the clock -> all outputs 0 before the next clock edge; HOURS_MODULO=12 run wraps 11:59:59 -> 00:00:00.
